// File: rtl/instruction_sequencer.sv
// Fetch/decode/execute controller for the 2-bit computer: 4-word program store, 2-bit accumulator.
// Optional single-step mode (step input, PAUSE state) is enabled by defining SEQ_SINGLE_STEP_EN.
module instruction_sequencer #(
  parameter int PROG_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       PC0,
  input  logic       PC1,
  input  logic       run,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic       step,
`endif
  input  logic       prog_we,
  input  logic [1:0] prog_addr,
  input  logic [3:0] prog_data,
  output logic       PC_step,
  output logic       PC_clear,
  output logic [3:0] IR,
  output logic [1:0] ACC,
  output logic       CARRY,
  output logic       HALTED,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_HALT,
    ST_PAUSE
  } state_t;

  localparam logic [1:0] OP_LDA  = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_JMP0 = 2'b10;
  localparam logic [1:0] OP_HLT  = 2'b11;

  state_t     state_q, state_d;
  logic [3:0] ir_q, ir_d;
  logic [1:0] opcode_q, opcode_d;
  logic [1:0] acc_q, acc_d;
  logic       carry_q, carry_d;
  logic       halted_q, halted_d;
  logic       pc_step_q, pc_step_d;
  logic       pc_clear_q, pc_clear_d;
  logic [2:0] sum;
  logic       mem_we;

  logic [3:0] mem_q [PROG_DEPTH];

  // Store is only writable while idle and never cleared, so a program survives Reset and HALT.
  assign mem_we = prog_we && (state_q == ST_IDLE) && !Reset;

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      ir_q       <= 4'd0;
      opcode_q   <= OP_LDA;
      acc_q      <= 2'd0;
      carry_q    <= 1'b0;
      halted_q   <= 1'b0;
      pc_step_q  <= 1'b0;
      pc_clear_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      opcode_q   <= opcode_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      halted_q   <= halted_d;
      pc_step_q  <= pc_step_d;
      pc_clear_q <= pc_clear_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    opcode_d   = opcode_q;
    acc_d      = acc_q;
    carry_d    = carry_q;
    halted_d   = halted_q;
    pc_step_d  = 1'b0;
    pc_clear_d = 1'b0;
    sum        = 3'd0;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        ir_d    = mem_q[{PC1, PC0}];
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        // Pulses are registered here so they are high for exactly the EXECUTE cycle.
        opcode_d   = ir_q[3:2];
        pc_step_d  = (ir_q[3:2] == OP_LDA) || (ir_q[3:2] == OP_ADD);
        pc_clear_d = (ir_q[3:2] == OP_JMP0);
        state_d    = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        case (opcode_q)
          OP_LDA: begin
            acc_d   = ir_q[1:0];
            carry_d = 1'b0;
          end
          OP_ADD: begin
            sum     = {1'b0, acc_q} + {1'b0, ir_q[1:0]};
            acc_d   = sum[1:0];
            carry_d = sum[2];
          end
          OP_JMP0: begin
            acc_d = acc_q;
          end
          default: begin
            halted_d = 1'b1;
          end
        endcase
        if (opcode_q == OP_HLT) begin
          state_d = ST_HALT;
        end else if (!run) begin
          state_d = ST_IDLE;
        end else begin
`ifdef SEQ_SINGLE_STEP_EN
          state_d = ST_PAUSE;
`else
          state_d = ST_FETCH;
`endif
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      ST_PAUSE: begin
`ifdef SEQ_SINGLE_STEP_EN
        if (!run) begin
          state_d = ST_IDLE;
        end else if (step) begin
          state_d = ST_FETCH;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign PC_step  = pc_step_q;
  assign PC_clear = pc_clear_q;
  assign IR       = ir_q;
  assign ACC      = acc_q;
  assign CARRY    = carry_q;
  assign HALTED   = halted_q;
  assign busy     = (state_q != ST_IDLE) && (state_q != ST_HALT);

endmodule
